// File: rtl/class_score_accumulator.sv
// class_score_accumulator
// Sums signed partial products per class lane with saturation and publishes
// the full packed score bus, with a one-cycle valid pulse, when the last term
// of a frame has been accepted.
module class_score_accumulator #(
    parameter int NUM_CLASS  = 10,
    parameter int DATA_WIDTH = 27,
    parameter int PROD_WIDTH = 16,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [PROD_WIDTH-1:0]           in_data,
    input  logic [IDX_WIDTH-1:0]            in_class,
    input  logic                            in_last,
    output logic [DATA_WIDTH*NUM_CLASS-1:0] layer_out,
    output logic                            valid,
    output logic                            sat_flag,
    output logic                            err_class,
    output logic [15:0]                     frame_cnt
);

    typedef enum logic {
        ACCUM   = 1'b0,
        PUBLISH = 1'b1
    } state_t;

    localparam logic [DATA_WIDTH-1:0] SAT_MAX   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [IDX_WIDTH:0]    CLASS_LIM = (IDX_WIDTH+1)'(NUM_CLASS);

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] acc [NUM_CLASS];
    logic                  frame_sat;
    logic                  accept;
    logic                  class_ok;
    logic [DATA_WIDTH-1:0] sel_acc;
    logic [DATA_WIDTH:0]   wide_sum;
    logic                  overflow;
    logic [DATA_WIDTH-1:0] sat_sum;

    assign accept   = in_valid & in_ready;
    assign class_ok = ({1'b0, in_class} < CLASS_LIM);

    // Select the addressed lane and form its saturated sum one bit wider than a lane.
    always_comb begin
        sel_acc = '0;
        for (int unsigned k = 0; k < NUM_CLASS; k++) begin
            if (in_class == IDX_WIDTH'(k)) begin
                sel_acc = acc[k];
            end
        end
        wide_sum = {sel_acc[DATA_WIDTH-1], sel_acc}
                 + {{(DATA_WIDTH+1-PROD_WIDTH){in_data[PROD_WIDTH-1]}}, in_data};
        overflow = wide_sum[DATA_WIDTH] != wide_sum[DATA_WIDTH-1];
        if (overflow) begin
            sat_sum = wide_sum[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
        end else begin
            sat_sum = wide_sum[DATA_WIDTH-1:0];
        end
    end

    // Next-state and handshake: PUBLISH is a single stall cycle after the last term.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (accept && in_last) begin
                    state_next = PUBLISH;
                end
            end
            PUBLISH: begin
                state_next = ACCUM;
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Per-lane accumulators; cleared once the frame has been copied out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NUM_CLASS; k++) begin
                acc[k] <= '0;
            end
        end else if (state == PUBLISH) begin
            for (int unsigned k = 0; k < NUM_CLASS; k++) begin
                acc[k] <= '0;
            end
        end else if (accept && class_ok) begin
            for (int unsigned k = 0; k < NUM_CLASS; k++) begin
                if (in_class == IDX_WIDTH'(k)) begin
                    acc[k] <= sat_sum;
                end
            end
        end
    end

    // Frame saturation tracking and sticky out-of-range class error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_sat <= 1'b0;
            err_class <= 1'b0;
        end else begin
            if (state == PUBLISH) begin
                frame_sat <= 1'b0;
            end else if (accept && class_ok && overflow) begin
                frame_sat <= 1'b1;
            end
            if (accept && !class_ok) begin
                err_class <= 1'b1;
            end
        end
    end

    // Publish registers: score bus held between publishes, valid pulses once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_out <= '0;
            valid     <= 1'b0;
            sat_flag  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            valid <= (state == PUBLISH);
            if (state == PUBLISH) begin
                for (int unsigned k = 0; k < NUM_CLASS; k++) begin
                    layer_out[k*DATA_WIDTH +: DATA_WIDTH] <= acc[k];
                end
                sat_flag  <= frame_sat;
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule
